bus_arbiter_mux: RTL and testbench

//  Parametrised, registered shared-bus driver for the datapath.
//  NUM_SRC sources each raise a request; an arbiter grants one owner.
//  The owner's data is registered onto the bus.

---
 rtl/bus_arbiter_mux.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus driver: round-robin arbitration with tenure limit and gapless handoff.
// Define BUS_FIXED_PRIORITY_EN to select lowest-index fixed priority instead of round-robin.
module bus_arbiter_mux #(
   parameter int WIDTH    = 32,
   parameter int NUM_SRC  = 32,
   parameter int SEL_W    = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC-1:0]       req,
   input  logic [NUM_SRC*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_valid,
   output logic [NUM_SRC-1:0]       grant,
   output logic [SEL_W-1:0]         owner
);

   localparam int HC_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int EXP_AT  = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t               r_state, w_state_nxt;
   logic [WIDTH-1:0]     r_bus_out, w_bus_nxt;
   logic                 r_bus_valid, w_valid_nxt;
   logic [NUM_SRC-1:0]   r_grant, w_grant_nxt;
   logic [SEL_W-1:0]     r_owner, w_owner_nxt;
   logic [HC_W-1:0]      r_hold_cnt, w_hold_nxt;
   logic                 w_take, w_excl, w_own_req, w_others, w_expire;
   logic [NUM_SRC-1:0]   w_cand;
   logic [SEL_W:0]       w_pick;
   logic [SEL_W-1:0]     w_win;
   logic [WIDTH-1:0]     w_data_win, w_data_own;

`ifdef BUS_FIXED_PRIORITY_EN
   // Lowest set index wins; the candidate mask already excludes a preempted owner.
   function automatic logic [SEL_W:0] f_pick(input logic [NUM_SRC-1:0] r);
      logic [SEL_W:0] res;
      res = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (r[i]) res = {1'b1, SEL_W'(i)};
      return res;
   endfunction

   assign w_pick = f_pick(w_cand);
`else
   logic [SEL_W-1:0]     r_last_owner, w_last_nxt;

   // Scan downward so the last hit is the nearest index after base (wrapping).
   function automatic logic [SEL_W:0] f_pick(input logic [NUM_SRC-1:0] r,
                                             input logic [SEL_W-1:0]   base);
      logic [SEL_W:0] res;
      int             idx;
      res = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = (int'(base) + k) % NUM_SRC;
         if (r[idx]) res = {1'b1, SEL_W'(idx)};
      end
      return res;
   endfunction

   assign w_pick = f_pick(w_cand, r_last_owner);
`endif

   assign w_win      = w_pick[SEL_W-1:0];
   assign w_cand     = w_excl ? (req & ~r_grant) : req;
   assign w_data_win = data_in[w_win*WIDTH +: WIDTH];
   assign w_data_own = data_in[r_owner*WIDTH +: WIDTH];
   assign w_own_req  = req[r_owner];
   assign w_others   = |(req & ~r_grant);
   // Once saturated, a newly arriving competitor preempts at the next edge.
   assign w_expire   = (MAX_HOLD != 0) && (r_hold_cnt >= HC_W'(EXP_AT))
                       && w_own_req && w_others;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bus_out   <= '0;
         r_bus_valid <= 1'b0;
         r_grant     <= '0;
         r_owner     <= '0;
         r_hold_cnt  <= '0;
`ifndef BUS_FIXED_PRIORITY_EN
         r_last_owner <= SEL_W'(NUM_SRC - 1);
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_bus_out   <= w_bus_nxt;
         r_bus_valid <= w_valid_nxt;
         r_grant     <= w_grant_nxt;
         r_owner     <= w_owner_nxt;
         r_hold_cnt  <= w_hold_nxt;
`ifndef BUS_FIXED_PRIORITY_EN
         r_last_owner <= w_last_nxt;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_excl      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_state_nxt = S_OWNED;
               w_take      = 1'b1;
            end
         end
         S_OWNED: begin
            if (!w_own_req) begin
               if (w_others) w_take = 1'b1;
               else          w_state_nxt = S_IDLE;
            end else if (w_expire) begin
               w_take = 1'b1;
               w_excl = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered-output next values
   always_comb begin
      w_bus_nxt   = r_bus_out;
      w_valid_nxt = r_bus_valid;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner;
      w_hold_nxt  = r_hold_cnt;
`ifndef BUS_FIXED_PRIORITY_EN
      w_last_nxt  = r_last_owner;
`endif
      if (w_take) begin
         w_grant_nxt = NUM_SRC'(1) << w_win;
         w_owner_nxt = w_win;
         w_hold_nxt  = '0;
         w_bus_nxt   = w_data_win;
         w_valid_nxt = 1'b1;
`ifndef BUS_FIXED_PRIORITY_EN
         w_last_nxt  = w_win;
`endif
      end else if (w_state_nxt == S_OWNED) begin
         w_bus_nxt   = w_data_own;
         w_valid_nxt = 1'b1;
         if (r_hold_cnt != HC_W'(MAX_HOLD)) w_hold_nxt = r_hold_cnt + 1'b1;
      end else begin
         w_bus_nxt   = '0;
         w_valid_nxt = 1'b0;
         w_grant_nxt = '0;
         w_hold_nxt  = '0;
      end
   end

   assign bus_out   = r_bus_out;
   assign bus_valid = r_bus_valid;
   assign grant     = r_grant;
   assign owner     = r_owner;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed testbench for bus_arbiter_mux (MAX_HOLD=4, 32 sources, 32-bit data).
module tb_bus_arbiter_mux;

   localparam int W = 32;
   localparam int N = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   data_in = '0;
   logic [W-1:0]     bus_out;
   logic             bus_valid;
   logic [N-1:0]     grant;
   logic [4:0]       owner;

   int n_cmp = 0;
   int n_bad = 0;

   bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .SEL_W(5), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset), .req(req), .data_in(data_in),
      .bus_out(bus_out), .bus_valid(bus_valid), .grant(grant), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic set_data(input int i, input logic [W-1:0] v);
      data_in[i*W +: W] = v;
   endtask

   initial begin
      // 1: reset and idle
      do_reset();
      chk("rst_owner", owner, 0);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("idle_bus", bus_out, 0);
         chk("idle_valid", bus_valid, 0);
         chk("idle_grant", grant, 0);
      end

      // 2: single requester, one-cycle latency, lone tenure never expires
      set_data(5, 32'hDEADBEEF);
      req[5] = 1'b1;
      step();
      chk("t2_grant", grant, 32'h20);
      chk("t2_owner", owner, 5);
      chk("t2_bus", bus_out, 32'hDEADBEEF);
      chk("t2_valid", bus_valid, 1);
      set_data(5, 32'h1);
      step();
      chk("t2_bus_upd", bus_out, 32'h1);
      for (int c = 0; c < 6; c++) step();
      chk("t2_lone_owner", owner, 5);
      chk("t2_lone_valid", bus_valid, 1);
      req = '0;
      step();
      chk("t2_idle_valid", bus_valid, 0);
      chk("t2_idle_bus", bus_out, 0);
      chk("t2_idle_grant", grant, 0);
      chk("t2_idle_owner", owner, 5);

      // 3: gapless handoff then idle
      do_reset();
      set_data(3, 32'h33);
      set_data(7, 32'h77);
      req[3] = 1'b1;
      req[7] = 1'b1;
      step();
      chk("t3_owner3", owner, 3);
      chk("t3_bus3", bus_out, 32'h33);
      step();
      chk("t3_owner3b", owner, 3);
      req[3] = 1'b0;
      step();
      chk("t3_owner7", owner, 7);
      chk("t3_grant7", grant, 32'h80);
      chk("t3_valid", bus_valid, 1);
      chk("t3_bus7", bus_out, 32'h77);
      req[7] = 1'b0;
      step();
      chk("t3_idle_valid", bus_valid, 0);
      chk("t3_idle_bus", bus_out, 0);
      chk("t3_idle_grant", grant, 0);

      // 4: tenure expiry alternates 2/9 every 4 cycles
      do_reset();
      set_data(2, 32'h22);
      set_data(9, 32'h99);
      req[2] = 1'b1;
      req[9] = 1'b1;
      for (int c = 0; c < 16; c++) begin
         step();
         chk($sformatf("t4_owner_c%0d", c), owner, ((c / 4) % 2 == 0) ? 2 : 9);
         chk($sformatf("t4_valid_c%0d", c), bus_valid, 1);
      end
      chk("t4_bus", bus_out, 32'h99);
      req = '0;
      step();

      // 5: wrap from last_owner=31, then selection from last_owner=3
      do_reset();
      req[0]  = 1'b1;
      req[30] = 1'b1;
      step();
      chk("t5_wrap_owner", owner, 0);
      chk("t5_wrap_grant", grant, 32'h1);
      req[0] = 1'b0;
      step();
      chk("t5_hand30", owner, 30);
      req = '0;
      step();
      req[3] = 1'b1;
      step();
      chk("t5_own3", owner, 3);
      req = '0;
      step();
      req[1] = 1'b1;
      req[5] = 1'b1;
      step();
`ifdef BUS_FIXED_PRIORITY_EN
      chk("t5_sel_after3", owner, 1);
`else
      chk("t5_sel_after3", owner, 5);
`endif
      req = '0;
      step();

      // 6: reset mid-transfer, regrant searches from index 0
      do_reset();
      req[7] = 1'b1;
      step();
      chk("t6_owner7", owner, 7);
      reset = 1'b1;
      step();
      chk("t6_rst_bus", bus_out, 0);
      chk("t6_rst_valid", bus_valid, 0);
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_owner", owner, 0);
      reset   = 1'b0;
      req[30] = 1'b1;
      step();
      chk("t6_regrant", owner, 7);
      chk("t6_regrant_grant", grant, 32'h80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
